// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM for the RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired instructions.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_ir, w_pc, w_mw, w_rw, w_ill;
  logic             w_lw, w_sw, w_r, w_i, w_jal, w_beq;

  assign w_lw  = (opcode == 7'b0000011);
  assign w_sw  = (opcode == 7'b0100011);
  assign w_r   = (opcode == 7'b0110011);
  assign w_i   = (opcode == 7'b0010011);
  assign w_jal = (opcode == 7'b1101111);
  assign w_beq = (opcode == 7'b1100011);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    w_next    = S_FETCH;
    ALUOp     = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    w_ir      = 1'b0;
    w_pc      = 1'b0;
    w_mw      = 1'b0;
    w_rw      = 1'b0;
    w_ill     = 1'b0;
    w_retire  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_ir      = mem_ready;
        w_pc      = mem_ready;
        w_next    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (1'b1)
          w_lw, w_sw: w_next = S_MEMADR;
          w_r:        w_next = S_EXECR;
          w_i:        w_next = S_EXECI;
          w_jal:      w_next = S_JAL;
          w_beq:      w_next = S_BEQ;
          default: begin
            w_next = S_FETCH;
            w_ill  = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = w_lw ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = 1'b1;
        w_retire  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        w_mw     = 1'b1;
        w_retire = mem_ready;
        w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw     = 1'b1;
        w_retire = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        w_pc    = 1'b1;
        w_next  = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        w_pc     = zero;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (1'b1)
      w_sw:    ImmSrc = 2'b01;
      w_beq:   ImmSrc = 2'b10;
      w_jal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // reset aborts the in-flight instruction: no architectural writes
  assign IRWrite  = w_ir  & ~rst;
  assign PCWrite  = w_pc  & ~rst;
  assign MemWrite = w_mw  & ~rst;
  assign RegWrite = w_rw  & ~rst;
  assign illegal  = w_ill & ~rst;
  assign state    = r_state;
  assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control.
// Per-cycle expectations are queued per scenario and compared as the FSM steps.
module tb_multicycle_main_control;

  logic        clk;
  logic        rst;
  logic [6:0]  op;
  logic        zero;
  logic        mr;
  logic [1:0]  aluop, srca, srcb, res, imm;
  logic        adr, irw, pcw, mw, rw, ill;
  logic [3:0]  st;
  logic [31:0] ret;
  logic [1:0]  aluop4, srca4, srcb4, res4, imm4;
  logic        adr4, irw4, pcw4, mw4, rw4, ill4;
  logic [3:0]  st4;
  logic [3:0]  ret4;

  typedef struct {
    logic        rst;
    logic        mr;
    logic        z;
    logic [3:0]  st;
    logic [31:0] ret;
  } item_t;

  item_t       q[$];
  logic [31:0] exp_ret;
  int          errors;
  int          checks;

  multicycle_main_control dut (
    .clk(clk), .rst(rst), .opcode(op), .zero(zero), .mem_ready(mr),
    .ALUOp(aluop), .ALUSrcA(srca), .ALUSrcB(srcb), .ResultSrc(res),
    .ImmSrc(imm), .AdrSrc(adr), .IRWrite(irw), .PCWrite(pcw),
    .MemWrite(mw), .RegWrite(rw), .illegal(ill), .state(st),
    .retired(ret)
  );

  multicycle_main_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(op), .zero(zero), .mem_ready(mr),
    .ALUOp(aluop4), .ALUSrcA(srca4), .ALUSrcB(srcb4), .ResultSrc(res4),
    .ImmSrc(imm4), .AdrSrc(adr4), .IRWrite(irw4), .PCWrite(pcw4),
    .MemWrite(mw4), .RegWrite(rw4), .illegal(ill4), .state(st4),
    .retired(ret4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output bundle derived from the per-state output table
  function automatic logic [15:0] model(input logic [3:0] s,
      input logic [6:0] o, input logic z, input logic m, input logic r);
    logic [1:0] a_op, a, b, rs, im;
    logic       ad, ir, pc, mwr, rwr, il;
    a_op = 2'b00; a = 2'b00; b = 2'b00; rs = 2'b00; im = 2'b00;
    ad = 1'b0; ir = 1'b0; pc = 1'b0; mwr = 1'b0; rwr = 1'b0; il = 1'b0;
    if (o == 7'b0100011)      im = 2'b01;
    else if (o == 7'b1100011) im = 2'b10;
    else if (o == 7'b1101111) im = 2'b11;
    case (s)
      4'd0:  begin b = 2'b10; rs = 2'b10; ir = m; pc = m; end
      4'd1:  begin
        a = 2'b01; b = 2'b01;
        il = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                         7'b0010011, 7'b1101111, 7'b1100011});
      end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  ad = 1'b1;
      4'd4:  begin rs = 2'b01; rwr = 1'b1; end
      4'd5:  begin ad = 1'b1; mwr = 1'b1; end
      4'd6:  begin a = 2'b10; a_op = 2'b10; end
      4'd7:  rwr = 1'b1;
      4'd8:  begin a = 2'b10; b = 2'b01; a_op = 2'b10; end
      4'd9:  begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      4'd10: begin a = 2'b10; a_op = 2'b01; pc = z; end
      default: ;
    endcase
    if (r) begin ir = 0; pc = 0; mwr = 0; rwr = 0; il = 0; end
    return {a_op, a, b, rs, im, ad, ir, pc, mwr, rwr, il};
  endfunction

  task automatic push(input logic [3:0] s, input logic m,
                      input logic z, input logic r);
    item_t it;
    it.rst = r; it.mr = m; it.z = z; it.st = s; it.ret = exp_ret;
    q.push_back(it);
  endtask

  // Drive one queued cycle, return observed and expected vectors
  task automatic cycle(output logic [55:0] ob, output logic [55:0] ex);
    item_t it;
    it = q.pop_front();
    rst = it.rst; mr = it.mr; zero = it.z;
    @(negedge clk);
    ob = {st, aluop, srca, srcb, res, imm, adr, irw, pcw, mw, rw, ill,
          ret, ret4};
    ex = {it.st, model(it.st, op, it.z, it.mr, it.rst), it.ret,
          it.ret[3:0]};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mr = 1'b1; zero = 1'b0; op = 7'b0110011;
    @(posedge clk);
    #1;
    exp_ret = '0;
  endtask

  task automatic test_reset();
    logic [55:0] ob, ex;
    do_reset();
    push(4'd0, 1'b1, 1'b0, 1'b1);
    push(4'd0, 1'b0, 1'b0, 1'b0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL reset: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_rtype();
    logic [55:0] ob, ex;
    op = 7'b0110011;
    push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0);
    push(4'd6, 1, 0, 0); push(4'd7, 1, 0, 0);
    exp_ret++;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL rtype: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_itype_jal();
    logic [55:0] ob, ex;
    op = 7'b0010011;
    push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0);
    push(4'd8, 0, 0, 0); push(4'd7, 0, 0, 0);
    exp_ret++;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL itype: got %h want %h", ob, ex);
      end
    end
    op = 7'b1101111;
    push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0);
    push(4'd9, 0, 0, 0); push(4'd7, 0, 0, 0);
    exp_ret++;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL jal: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [55:0] ob, ex;
    op = 7'b0000011;
    push(4'd0, 1, 0, 0); push(4'd1, 0, 0, 0); push(4'd2, 0, 0, 0);
    push(4'd3, 0, 0, 0); push(4'd3, 0, 0, 0); push(4'd3, 1, 0, 0);
    push(4'd4, 0, 0, 0);
    exp_ret++;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL lw: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [55:0] ob, ex;
    op = 7'b0100011;
    push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0); push(4'd2, 1, 0, 0);
    push(4'd5, 0, 0, 0); push(4'd5, 1, 0, 0);
    exp_ret++;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL sw: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_beq();
    logic [55:0] ob, ex;
    op = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0);
      push(4'd10, 1, z[0], 0);
      exp_ret++;
      push(4'd0, 0, 0, 0);
      while (q.size() > 0) begin
        cycle(ob, ex);
        checks++;
        if (ob !== ex) begin
          errors++;
          $display("FAIL beq z=%0d: got %h want %h", z, ob, ex);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [55:0] ob, ex;
    op = 7'b1111111;
    push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0);
    push(4'd0, 0, 0, 0); push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL illegal: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_fetch_stall();
    logic [55:0] ob, ex;
    op = 7'b0110011;
    push(4'd0, 0, 0, 0); push(4'd0, 0, 0, 0); push(4'd0, 0, 0, 0);
    push(4'd0, 1, 0, 0); push(4'd1, 0, 0, 0);
    push(4'd6, 0, 0, 0); push(4'd7, 0, 0, 0);
    exp_ret++;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL fetch_stall: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [55:0] ob, ex;
    op = 7'b0100011;
    push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0); push(4'd2, 1, 0, 0);
    push(4'd5, 0, 0, 0); push(4'd5, 1, 0, 1);
    exp_ret = '0;
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL reset_mid: got %h want %h", ob, ex);
      end
    end
  endtask

  task automatic test_wrap();
    logic [55:0] ob, ex;
    op = 7'b1100011;
    for (int n = 0; n < 17; n++) begin
      push(4'd0, 1, 0, 0); push(4'd1, 1, 0, 0);
      push(4'd10, 1, n[0], 0);
      exp_ret++;
    end
    push(4'd0, 0, 0, 0);
    while (q.size() > 0) begin
      cycle(ob, ex);
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL wrap: got %h want %h", ob, ex);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_ret = '0;
    rst = 1'b1; mr = 1'b0; zero = 1'b0; op = 7'b0;
    test_reset();
    test_rtype();
    test_itype_jal();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_fetch_stall();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
# multicycle_main_control

Multicycle main control FSM for the RISC-V datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the mux selects and write strobes, plus the 2-bit `ALUOp` consumed by the downstream ALU control decoder. Also stalls on a memory-ready handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  instr[6:0] from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory has completed the current access this cycle
- `ALUOp`  out  2  00 add, 01 sub/branch, 10 use func3/func7
- `ALUSrcA`  out  2  00 PC, 01 OldPC, 10 rs1
- `ALUSrcB`  out  2  00 rs2, 01 imm, 10 constant 4
- `ResultSrc`  out  2  00 ALUOut, 01 mem data, 10 ALU result
- `ImmSrc`  out  2  00 I, 01 S, 10 B, 11 J
- `AdrSrc`  out  1  0 PC, 1 ALUOut
- `IRWrite`, `PCWrite`, `MemWrite`, `RegWrite`  out  1 each  write strobes
- `illegal`  out  1  one-cycle pulse on an unsupported opcode
- `state`  out  4  current state encoding, for debug
- `retired`  out  CNT_W  count of completed instructions

## Operation
State encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
- EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10
- 11–15 are unused and go to FETCH on the next edge.

Outputs not listed for a state are 0. Outputs are Moore; the exceptions are strobes gated by `mem_ready` or `zero`.

State behaviour:
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch/jump target). Next state by opcode:
  - 0000011 (lw) and 0100011 (sw) → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 → BEQ
  - any other opcode → FETCH, with `illegal`=1 for this cycle
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if the opcode is lw, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 (held every cycle while waiting). Goes to FETCH on mem_ready=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 → ALUWB (writes PC+4 to rd).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero → FETCH.

ImmSrc is combinational from `opcode` in every state:
- 0100011 → 01
- 1100011 → 10
- 1101111 → 11
- anything else → 00

Retired counter:
- Increments by 1 on the edge leaving MEMWB, ALUWB or BEQ to FETCH.
- Also increments on the edge leaving MEMWRITE with mem_ready=1.
- Illegal opcodes do not increment it.
- Wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset: on a rising edge with rst=1, state←FETCH, retired←0, illegal←0.
- While rst=1, all four write strobes are forced to 0 regardless of state or mem_ready.
- Reset mid-instruction aborts it: no write strobe is asserted and the counter is not incremented on that edge.
- Latency with mem_ready tied to 1:
  - lw: 5 cycles
  - sw, R-type, I-type, jal: 4 cycles
  - beq: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- IRWrite/PCWrite in FETCH and MemWrite completion occur only in the cycle where mem_ready=1.
- `mem_ready` is ignored in every other state.
- `opcode` is sampled in DECODE and MEMADR. It is stable there because IRWrite is 0 outside FETCH.
- Write strobes never assert in two consecutive states for the same instruction, except JAL→ALUWB (PCWrite, then RegWrite).

## Test plan
- R-type: reset, then opcode=0110011, mem_ready=1.
  - state sequence 0,1,6,7,0
  - ALUOp=10 in EXECR
  - RegWrite=1 only in ALUWB
  - retired 0→1
- lw with memory wait: opcode=0000011; hold mem_ready=0 for 2 cycles in MEMREAD.
  - sequence 0,1,2,3,3,3,4,0 (8 cycles)
  - AdrSrc=1 throughout MEMREAD
  - RegWrite/ResultSrc=01 in MEMWB
- sw: opcode=0100011; mem_ready=0 for 1 cycle in MEMWRITE.
  - MemWrite=1 for both MEMWRITE cycles, ImmSrc=01
  - retired increments once, on the ready edge
- beq: opcode=1100011.
  - with zero=1: PCWrite=1 in BEQ
  - with zero=0: PCWrite=0
  - ALUOp=01, ImmSrc=10; retired increments in both cases
- Illegal/reset: opcode=1111111 → illegal=1 in DECODE for one cycle, then FETCH, retired unchanged.
  - Assert rst during MEMWRITE: strobes=0 that cycle, next state=0, retired=0.
- Fetch stall and wrap: mem_ready=0 for 3 cycles in FETCH → IRWrite=PCWrite=0 for those cycles, then 1 for one cycle.
  - With CNT_W=4, 16 instructions retired returns retired to 0.
